// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite pixel fetch path.
// Used by sprite_anim_fsm and sprite_pixel_fetch.
package sprite_pkg;

   localparam int COORD_W = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WALK   = 2'd1,
      ATTACK = 2'd2
   } anim_state_t;

   localparam logic [1:0] ANIM_IDLE   = 2'b00;
   localparam logic [1:0] ANIM_WALK   = 2'b01;
   localparam logic [1:0] ANIM_ATTACK = 2'b10;

endpackage

// File: rtl/sprite_anim_fsm.sv
// Sprite animation state: vsync edge detect, tick counter,
// idle/walk/attack state and the current animation frame.
module sprite_anim_fsm
   import sprite_pkg::*;
#(
   parameter int FRAMES      = 4,
   parameter int FRAME_TICKS = 8
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       vsync,
   input  logic [1:0] anim_req,
   output logic       frame_tick,
   output logic [1:0] frame_sel,
   output logic       attack_active
);

   localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);
   localparam logic [1:0] FRAME_LAST = 2'(FRAMES - 1);

   logic             vsync_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [1:0]       frame_nx;
   anim_state_t      state;
   anim_state_t      state_nx;
   logic             cnt_wrap;
   logic             frame_wrap;

   // History starts high so a vsync already high at reset release is not an edge
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) vsync_q <= 1'b1;
      else          vsync_q <= vsync;
   end

   assign frame_tick    = vsync & ~vsync_q;
   assign cnt_wrap      = (cnt == CNT_LAST);
   assign frame_wrap    = (frame_sel == FRAME_LAST);
   assign attack_active = (state == ATTACK);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      frame_nx = frame_sel;
      case (state)
         IDLE: begin
            cnt_nx   = '0;
            frame_nx = '0;
            if (anim_req == ANIM_WALK)
               state_nx = WALK;
            else if (anim_req == ANIM_ATTACK)
               state_nx = ATTACK;
         end
         WALK: begin
            if (anim_req == ANIM_ATTACK) begin
               state_nx = ATTACK;
               cnt_nx   = '0;
               frame_nx = '0;
            end else if (anim_req == ANIM_WALK) begin
               if (cnt_wrap) begin
                  cnt_nx   = '0;
                  frame_nx = frame_wrap ? 2'd0 : frame_sel + 2'd1;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end else begin
               state_nx = IDLE;
               cnt_nx   = '0;
               frame_nx = '0;
            end
         end
         ATTACK: begin
            // Plays once to the end; anim_req only matters on the final tick
            if (cnt_wrap) begin
               cnt_nx = '0;
               if (frame_wrap) begin
                  frame_nx = '0;
                  state_nx = (anim_req == ANIM_WALK) ? WALK : IDLE;
               end else begin
                  frame_nx = frame_sel + 2'd1;
               end
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            frame_nx = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         frame_sel <= '0;
      end else if (frame_tick) begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         frame_sel <= frame_nx;
      end
   end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite ROM address generation and palette index alignment (3-cycle pipe).
// Optional ANIM_MIRROR_EN adds mirror_x for horizontally flipped drawing.
module sprite_pixel_fetch #(
   parameter int SPRITE_W    = 32,
   parameter int SPRITE_H    = 32,
   parameter int FRAMES      = 4,
   parameter int IDX_W       = 3,
   parameter int TRANSP_IDX  = 0,
   parameter int FRAME_TICKS = 8,
   parameter int COORD_W     = sprite_pkg::COORD_W,
   parameter int ADDR_W      = 12
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               vsync,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   input  logic [COORD_W-1:0] spr_x,
   input  logic [COORD_W-1:0] spr_y,
   input  logic [1:0]         anim_req,
`ifdef ANIM_MIRROR_EN
   input  logic               mirror_x,
`endif
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [IDX_W-1:0]   rom_q,
   output logic [IDX_W-1:0]   pix_idx,
   output logic               pix_opaque,
   output logic [1:0]         frame_sel,
   output logic               attack_active
);

   localparam int XW = $clog2(SPRITE_W);
   localparam int YW = $clog2(SPRITE_H);
   localparam logic [COORD_W:0] W_LIM = (COORD_W+1)'(SPRITE_W);
   localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(SPRITE_H);
   localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSP_IDX);

   logic               frame_tick;
   logic [COORD_W-1:0] spr_x_l;
   logic [COORD_W-1:0] spr_y_l;
   logic [COORD_W:0]   dx;
   logic [COORD_W:0]   dy;
   logic [XW-1:0]      col;
   logic               hit;
   logic               hit_d1;
   logic               hit_d2;
   logic               opaque_nx;
   logic [ADDR_W-1:0]  addr_nx;

   sprite_anim_fsm #(
      .FRAMES      (FRAMES),
      .FRAME_TICKS (FRAME_TICKS)
   ) u_anim (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .vsync         (vsync),
      .anim_req      (anim_req),
      .frame_tick    (frame_tick),
      .frame_sel     (frame_sel),
      .attack_active (attack_active)
   );

   // Position only moves between frames so a sprite never tears mid-scan
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         spr_x_l <= '0;
         spr_y_l <= '0;
      end else if (frame_tick) begin
         spr_x_l <= spr_x;
         spr_y_l <= spr_y;
      end
   end

   assign dx  = {1'b0, DrawX} - {1'b0, spr_x_l};
   assign dy  = {1'b0, DrawY} - {1'b0, spr_y_l};
   assign hit = !dx[COORD_W] && (dx < W_LIM) &&
                !dy[COORD_W] && (dy < H_LIM);

`ifdef ANIM_MIRROR_EN
   logic mirror_l;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)        mirror_l <= 1'b0;
      else if (frame_tick) mirror_l <= mirror_x;
   end

   // W is a power of two, so W-1-dx is the bitwise inverse of dx
   assign col = mirror_l ? ~dx[XW-1:0] : dx[XW-1:0];
`else
   assign col = dx[XW-1:0];
`endif

   assign addr_nx = ADDR_W'(frame_sel) * ADDR_W'(SPRITE_W * SPRITE_H) +
                    ADDR_W'(dy[YW-1:0]) * ADDR_W'(SPRITE_W) +
                    ADDR_W'(col);

   assign opaque_nx = hit_d2 && (rom_q != TRANSP);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rom_addr   <= '0;
         hit_d1     <= 1'b0;
         hit_d2     <= 1'b0;
         pix_opaque <= 1'b0;
         pix_idx    <= '0;
      end else begin
         rom_addr   <= hit ? addr_nx : '0;
         hit_d1     <= hit;
         hit_d2     <= hit_d1;
         pix_opaque <= opaque_nx;
         pix_idx    <= opaque_nx ? rom_q : TRANSP;
      end
   end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Bench for sprite_pixel_fetch with a tick-count animation model.
module tb_sprite_pixel_fetch;

   localparam int FT  = 8;
   localparam int FR  = 4;
   localparam int SW  = 32;
   localparam int SH  = 32;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        vsync;
   logic [9:0]  DrawX, DrawY, spr_x, spr_y;
   logic [1:0]  anim_req;
   logic [11:0] rom_addr;
   logic [2:0]  rom_q, rom_drv, rom_mem_q;
   logic        rom_en;
   logic [2:0]  pix_idx;
   logic        pix_opaque;
   logic [1:0]  frame_sel;
   logic        attack_active;
   logic [2:0]  mem [0:4095];

   int checks = 0;
   int failures = 0;
   int m_sx, m_sy, m_mode, m_n;
   logic [11:0] got_addr;
   logic [2:0]  got_idx;
   logic        got_op;

   sprite_pixel_fetch dut (
      .Clk(Clk), .Reset_n(Reset_n), .vsync(vsync),
      .DrawX(DrawX), .DrawY(DrawY), .spr_x(spr_x), .spr_y(spr_y),
      .anim_req(anim_req), .rom_addr(rom_addr), .rom_q(rom_q),
      .pix_idx(pix_idx), .pix_opaque(pix_opaque),
      .frame_sel(frame_sel), .attack_active(attack_active)
   );

   always #5 Clk = ~Clk;
   assign rom_q = rom_en ? rom_mem_q : rom_drv;
   always @(posedge Clk) rom_mem_q <= mem[rom_addr];

   // Model: mode 0 idle, 1 walk, 2 attack; n = ticks since entering mode
   function automatic int m_frame();
      if (m_mode == 1) return (m_n / FT) % FR;
      if (m_mode == 2) return m_n / FT;
      return 0;
   endfunction

   function automatic void m_tick(input int req, input int sx, input int sy);
      m_sx = sx;
      m_sy = sy;
      case (m_mode)
         0: begin
            if (req == 1) begin m_mode = 1; m_n = 0; end
            else if (req == 2) begin m_mode = 2; m_n = 0; end
         end
         1: begin
            if (req == 2) begin m_mode = 2; m_n = 0; end
            else if (req == 1) m_n++;
            else begin m_mode = 0; m_n = 0; end
         end
         default: begin
            m_n++;
            if (m_n == FT * FR) begin
               m_mode = (req == 1) ? 1 : 0;
               m_n = 0;
            end
         end
      endcase
   endfunction

   function automatic int m_hit(input int x, input int y);
      return (x >= m_sx && x < m_sx + SW && y >= m_sy && y < m_sy + SH) ? 1 : 0;
   endfunction

   function automatic int m_addr(input int x, input int y);
      if (m_hit(x, y) == 0) return 0;
      return m_frame() * SW * SH + (y - m_sy) * SW + (x - m_sx);
   endfunction

   task automatic tick();
      @(negedge Clk);
      vsync = 1'b1;
      m_tick(int'(anim_req), int'(spr_x), int'(spr_y));
      @(negedge Clk);
      vsync = 1'b0;
      @(negedge Clk);
   endtask

   task automatic pixel(input int x, input int y, input logic [2:0] q);
      @(negedge Clk);
      DrawX = 10'(x);
      DrawY = 10'(y);
      @(posedge Clk);
      #1 got_addr = rom_addr;
      rom_drv = q;
      @(posedge Clk);
      @(posedge Clk);
      #1 got_idx = pix_idx;
      got_op = pix_opaque;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; vsync = 1'b1; anim_req = 2'b01;
      spr_x = 10'd100; spr_y = 10'd50;
      DrawX = '0; DrawY = '0; rom_drv = '0; rom_en = 1'b0;
      m_mode = 0; m_n = 0; m_sx = 0; m_sy = 0;
      repeat (3) @(negedge Clk);
      checks++;
      if ({rom_addr, pix_idx, pix_opaque, frame_sel, attack_active} !== 19'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {rom_addr, pix_idx, pix_opaque, frame_sel, attack_active});
      end
      Reset_n = 1'b1;
      repeat (4) @(negedge Clk);
      checks++;
      if (frame_sel !== 2'd0 || attack_active !== 1'b0 || pix_opaque !== 1'b0) begin
         failures++;
         $display("FAIL reset_release frame=%0d att=%0d op=%0d exp=0/0/0",
                  frame_sel, attack_active, pix_opaque);
      end
      pixel(105, 52, 3'd5);
      checks++;
      if (got_addr !== 12'd0 || got_op !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_tick addr=%0d op=%0d exp=0/0", got_addr, got_op);
      end
      anim_req = 2'b00;
      vsync = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_hit();
      anim_req = 2'b00; spr_x = 10'd100; spr_y = 10'd50;
      tick();
      pixel(105, 52, 3'd5);
      checks++;
      if (got_addr !== 12'd69 || got_idx !== 3'd5 || got_op !== 1'b1) begin
         failures++;
         $display("FAIL hit addr=%0d idx=%0d op=%0d exp=69/5/1", got_addr, got_idx, got_op);
      end
   endtask

   task automatic test_edges();
      int tx [8] = '{99, 131, 132, 105, 105, 105, 105, 100};
      int ty [8] = '{52, 52, 52, 52, 49, 81, 82, 50};
      int tq [8] = '{5, 3, 3, 0, 4, 4, 4, 7};
      int ta [8] = '{0, 95, 0, 69, 0, 997, 0, 0};
      int ti [8] = '{0, 3, 0, 0, 0, 4, 0, 7};
      int to [8] = '{0, 1, 0, 0, 0, 1, 0, 1};
      for (int i = 0; i < 8; i++) begin
         pixel(tx[i], ty[i], 3'(tq[i]));
         checks++;
         if (got_addr !== 12'(ta[i]) || got_idx !== 3'(ti[i]) || got_op !== 1'(to[i])) begin
            failures++;
            $display("FAIL edge%0d addr=%0d idx=%0d op=%0d exp=%0d/%0d/%0d",
                     i, got_addr, got_idx, got_op, ta[i], ti[i], to[i]);
         end
      end
   endtask

   task automatic test_walk();
      bit seen2 = 0;
      anim_req = 2'b01;
      for (int i = 0; i < 33; i++) begin
         tick();
         checks++;
         if (frame_sel !== 2'(m_frame()) || attack_active !== 1'b0) begin
            failures++;
            $display("FAIL walk_t%0d frame=%0d att=%0d exp=%0d/0",
                     i, frame_sel, attack_active, m_frame());
         end
         if (m_frame() == 2 && !seen2) begin
            seen2 = 1;
            pixel(100, 50, 3'd6);
            checks++;
            if (got_addr !== 12'd2048 || got_idx !== 3'd6) begin
               failures++;
               $display("FAIL walk_addr addr=%0d idx=%0d exp=2048/6", got_addr, got_idx);
            end
         end
      end
      checks++;
      if (frame_sel !== 2'd0) begin
         failures++;
         $display("FAIL walk_wrap frame=%0d exp=0", frame_sel);
      end
   endtask

   task automatic test_attack();
      int active = 0;
      anim_req = 2'b10;
      tick();
      if (attack_active === 1'b1) active++;
      for (int i = 1; i <= 32; i++) begin
         if (i >= 10 && i < 20) anim_req = 2'b00;
         else if (i >= 20 && i < 25) anim_req = 2'b10;
         else anim_req = 2'b01;
         tick();
         if (attack_active === 1'b1) active++;
         checks++;
         if (frame_sel !== 2'(m_frame()) || attack_active !== (m_mode == 2)) begin
            failures++;
            $display("FAIL attack_t%0d frame=%0d att=%0d exp=%0d/%0d",
                     i, frame_sel, attack_active, m_frame(), m_mode == 2);
         end
      end
      checks++;
      if (active !== 32 || frame_sel !== 2'd0 || attack_active !== 1'b0) begin
         failures++;
         $display("FAIL attack_len active=%0d frame=%0d att=%0d exp=32/0/0",
                  active, frame_sel, attack_active);
      end
      tick();
      checks++;
      if (frame_sel !== 2'(m_frame()) || m_mode != 1) begin
         failures++;
         $display("FAIL attack_to_walk frame=%0d mode=%0d exp=%0d/1",
                  frame_sel, m_mode, m_frame());
      end
   endtask

   task automatic test_latch();
      anim_req = 2'b00;
      tick();
      spr_x = 10'd200;
      pixel(105, 52, 3'd2);
      checks++;
      if (got_addr !== 12'd69 || got_op !== 1'b1) begin
         failures++;
         $display("FAIL latch_hold addr=%0d op=%0d exp=69/1", got_addr, got_op);
      end
      tick();
      pixel(205, 52, 3'd2);
      checks++;
      if (got_addr !== 12'd69 || got_op !== 1'b1) begin
         failures++;
         $display("FAIL latch_new addr=%0d op=%0d exp=69/1", got_addr, got_op);
      end
      pixel(105, 52, 3'd2);
      checks++;
      if (got_addr !== 12'd0 || got_op !== 1'b0) begin
         failures++;
         $display("FAIL latch_old addr=%0d op=%0d exp=0/0", got_addr, got_op);
      end
   endtask

   task automatic test_random();
      int x, y;
      logic [2:0] q;
      logic [11:0] ea;
      logic eo;
      for (int i = 0; i < 80; i++) begin
         if (i % 4 == 0) begin
            anim_req = 2'($urandom_range(0, 3));
            spr_x = 10'($urandom_range(0, 1023));
            spr_y = 10'($urandom_range(0, 1023));
            tick();
            checks++;
            if (frame_sel !== 2'(m_frame()) || attack_active !== (m_mode == 2)) begin
               failures++;
               $display("FAIL rand_anim%0d frame=%0d att=%0d exp=%0d/%0d",
                        i, frame_sel, attack_active, m_frame(), m_mode == 2);
            end
         end
         x = (m_sx + 1020 + int'($urandom_range(0, 40))) % 1024;
         y = (m_sy + 1020 + int'($urandom_range(0, 40))) % 1024;
         q = 3'($urandom_range(0, 7));
         pixel(x, y, q);
         ea = 12'(m_addr(x, y));
         eo = (m_hit(x, y) != 0) && (q != 3'd0);
         checks++;
         if (got_addr !== ea || got_op !== eo || got_idx !== (eo ? q : 3'd0)) begin
            failures++;
            $display("FAIL rand_pix%0d x=%0d y=%0d addr=%0d op=%0d idx=%0d exp=%0d/%0d/%0d",
                     i, x, y, got_addr, got_op, got_idx, ea, eo, eo ? q : 3'd0);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] ea [200];
      logic [2:0]  ei [200];
      logic        eo [200];
      int x, y;
      for (int a = 0; a < 4096; a++) mem[a] = 3'($urandom_range(0, 7));
      rom_en = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge Clk);
         if (k >= 1) begin
            checks++;
            if (rom_addr !== ea[k-1]) begin
               failures++;
               $display("FAIL b2b_addr%0d got=%0d exp=%0d", k, rom_addr, ea[k-1]);
            end
         end
         if (k >= 3) begin
            checks++;
            if (pix_idx !== ei[k-3] || pix_opaque !== eo[k-3]) begin
               failures++;
               $display("FAIL b2b_pix%0d idx=%0d op=%0d exp=%0d/%0d",
                        k, pix_idx, pix_opaque, ei[k-3], eo[k-3]);
            end
         end
         x = (m_sx + 1016 + int'($urandom_range(0, 48))) % 1024;
         y = (m_sy + 1016 + int'($urandom_range(0, 48))) % 1024;
         DrawX = 10'(x);
         DrawY = 10'(y);
         ea[k] = 12'(m_addr(x, y));
         eo[k] = (m_hit(x, y) != 0) && (mem[ea[k]] != 3'd0);
         ei[k] = eo[k] ? mem[ea[k]] : 3'd0;
      end
      rom_en = 1'b0;
   endtask

   task automatic test_reset_mid_attack();
      anim_req = 2'b00; spr_x = 10'd100; spr_y = 10'd50;
      repeat (34) tick();
      anim_req = 2'b10;
      tick();
      anim_req = 2'b00;
      repeat (10) tick();
      pixel(110, 60, 3'd5);
      checks++;
      if (got_addr !== 12'd1354 || got_op !== 1'b1 || attack_active !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset addr=%0d op=%0d att=%0d exp=1354/1/1",
                  got_addr, got_op, attack_active);
      end
      @(posedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      checks++;
      if ({rom_addr, pix_idx, pix_opaque, frame_sel, attack_active} !== 19'd0) begin
         failures++;
         $display("FAIL mid_reset got=%h exp=0",
                  {rom_addr, pix_idx, pix_opaque, frame_sel, attack_active});
      end
      m_mode = 0; m_n = 0; m_sx = 0; m_sy = 0;
      @(negedge Clk);
      Reset_n = 1'b1;
      tick();
      pixel(110, 60, 3'd5);
      checks++;
      if (got_addr !== 12'(m_addr(110, 60)) || attack_active !== 1'b0 || frame_sel !== 2'd0) begin
         failures++;
         $display("FAIL post_reset addr=%0d att=%0d frame=%0d exp=%0d/0/0",
                  got_addr, attack_active, frame_sel, m_addr(110, 60));
      end
   endtask

   initial begin
      test_reset();
      test_hit();
      test_edges();
      test_walk();
      test_attack();
      test_latch();
      test_random();
      test_back_to_back();
      test_reset_mid_attack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sprite_pixel_fetch.md
Name: sprite_pixel_fetch

Overview:
Upstream feeder for the per-sprite palette lookup modules. It takes the VGA controller's draw coordinates and a sprite's on-screen position, and generates the sprite ROM address. It then turns the ROM's returned colour index into an aligned palette index with an opaque flag, which the palette module and compositor consume. It also owns the sprite's animation state (idle, walk, attack) and advances the animation frame on vertical-sync ticks.

Parameters:
SPRITE_W, 32, sprite width in pixels (power of 2)
SPRITE_H, 32, sprite height in pixels (power of 2)
FRAMES, 4, animation frames stored back-to-back in the ROM
IDX_W, 3, palette index width (matches the 8-entry sprite palettes)
TRANSP_IDX, 0, colour index treated as transparent
FRAME_TICKS, 8, vsync ticks per animation frame
COORD_W, 10, DrawX/DrawY and sprite position width
ADDR_W, 12, ROM address width; equals clog2(SPRITE_W*SPRITE_H*FRAMES)

Ports:
Clk  in  1  system/pixel clock
Reset_n  in  1  asynchronous active-low reset
vsync  in  1  VGA vertical sync (active high)
DrawX  in  COORD_W  current pixel column
DrawY  in  COORD_W  current pixel row
spr_x  in  COORD_W  sprite top-left column
spr_y  in  COORD_W  sprite top-left row
anim_req  in  2  00 idle, 01 walk, 10 attack, 11 treated as idle
rom_addr  out  ADDR_W  sprite ROM address (registered)
rom_q  in  IDX_W  ROM data; valid one cycle after rom_addr
pix_idx  out  IDX_W  palette index to the palette module
pix_opaque  out  1  high when the sprite covers this pixel and the pixel is not transparent
frame_sel  out  2  current animation frame
attack_active  out  1  high while the attack sequence plays

Behaviour:
- Clocking and reset: one clock, Clk. Reset_n is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; tick counter 0; latched position 0.
- vsync edge detector: its history register resets to 1, so vsync held high at reset release produces no tick.
- frame_tick: one-cycle pulse on each vsync rising edge.
- Position latch: spr_x and spr_y are captured only on frame_tick. A position change mid-frame takes effect next frame (no tearing).
- Hit test (cycle N): dx = DrawX - spr_x_l and dy = DrawY - spr_y_l, both computed at COORD_W+1 bits.
  - hit = (dx non-negative and dx < SPRITE_W) and (dy non-negative and dy < SPRITE_H).
  - A box that extends past the screen edge is not special-cased.
- Address generation: rom_addr = frame_sel*SPRITE_W*SPRITE_H + dy*SPRITE_H-row stride SPRITE_W + dx, i.e. frame_sel*W*H + dy*W + dx.
  - Registered; visible at cycle N+1.
  - Forced to 0 when there is no hit.
- ROM data: rom_q is valid at N+2, aligned with the two-stage delayed hit.
- Output stage: registered, visible at N+3 (total latency 3 cycles).
  - pix_opaque = hit_d2 and (rom_q != TRANSP_IDX).
  - pix_idx = rom_q when pix_opaque, else TRANSP_IDX.
- Animation FSM (sampled only on frame_tick):
  - IDLE: frame_sel = 0, tick counter 0. anim_req=01 moves to WALK; anim_req=10 moves to ATTACK.
  - WALK: the tick counter counts frame_ticks. At FRAME_TICKS-1 the counter clears and frame_sel increments, wrapping FRAMES-1 to 0. anim_req=00 or 11 returns to IDLE (frame 0). anim_req=10 enters ATTACK with frame 0.
  - ATTACK: attack_active = 1. frame_sel steps 0 to FRAMES-1 once, FRAME_TICKS ticks per frame. It cannot be interrupted; anim_req is ignored until the sequence ends.
  - End of ATTACK: on the tick that would wrap past FRAMES-1, the FSM goes to WALK if anim_req=01, else IDLE, with frame_sel = 0.
- Simultaneous events: a frame_tick in the same cycle as a pixel uses the old latched position and frame for that pixel.
- Reset mid-attack: the FSM returns to IDLE immediately and the pipeline flushes to zeros.

Optional Feature:
ANIM_MIRROR_EN
- Defined: adds input port mirror_x (1 bit), latched on frame_tick. When set, the address uses dx' = SPRITE_W-1-dx, so left-facing art is drawn from right-facing ROM. Latency is unchanged.
- Undefined: the port is absent and no mirroring logic is built.

Decomposition:
- Package sprite_pkg: anim_state_t enum (IDLE, WALK, ATTACK), anim_req codes (ANIM_IDLE, ANIM_WALK, ANIM_ATTACK), and shared COORD_W.
- Sub-module sprite_anim_fsm: vsync edge detect, tick counter, state and frame_sel. The top level holds the position latch and the three-stage pixel pipeline.

Test Plan:
- Reset: Reset_n=0 with vsync=1, then release with vsync still high -> no tick; all outputs 0; frame_sel=0.
- Hit: latch spr_x=100, spr_y=50; frame 0; DrawX=105, DrawY=52 -> rom_addr=69 at N+1; rom_q=5 at N+2 -> pix_idx=5 and pix_opaque=1 at N+3.
- Edges: DrawX=99 -> rom_addr=0, opaque=0; DrawX=131 -> hit (dx=31); DrawX=132 -> miss; in-box rom_q=0 -> pix_idx=0, opaque=0.
- Walk: anim_req=01 -> frame_sel advances every 8 ticks, 0,1,2,3,0; at frame 2 with dx=dy=0 -> rom_addr=2048.
- Attack: anim_req=10 for one tick, then 01 -> attack_active=1 for 32 ticks, frames 0 to 3; anim_req=00 mid-attack ignored; then WALK at frame 0.
- Latch: change spr_x from 100 to 200 without vsync -> DrawX=105 still hits; after next tick, DrawX=205 hits and 105 misses.
